rush3d_framebuffer_writer: RTL
==============================

// Module: rush3d_framebuffer_writer
// PURPOSE
// Drains rasterised pixels from the pixel FIFO and writes them to the back framebuffer in SDRAM over an
// Avalon-MM write master. Performs background fills on request from rush3d_controller. Reports its state on
// framebuffer_write_state, which the controller polls. Back buffer is always the one not being scanned out.
// PARAMETERS
// H_RES      640           framebuffer width in pixels
// V_RES      480           framebuffer height in pixels
// BUF0_BASE  32'h0000_0000 byte base address of buffer 0
// BUF1_BASE  32'h0012_C000 byte base address of buffer 1
// PORTS
// clock                   in   1   system clock, all logic posedge
// reset                   in   1   asynchronous, active-high reset
// fill_background_flag    in   1   level request from controller; rising edge starts a fill
// background_colour       in   32  ARGB fill colour, sampled on BACKGROUND entry
// current_buffer_flag     in   1   displayed buffer: 0 -> draw to BUF1, 1 -> draw to BUF0
// pixel_fifo_data         in   52  show-ahead word {y[51:42], x[41:32], colour[31:0]}
// pixel_fifo_empty        in   1   FIFO empty
// pixel_fifo_rdreq        out  1   pop strobe, one word per asserted cycle
// avm_address             out  32  byte address, base + (y*H_RES + x)*4
// avm_writedata           out  32  pixel colour
// avm_write               out  1   write request
// avm_waitrequest         in   1   slave stall; transfer accepted on cycle write=1 && waitrequest=0
// framebuffer_write_state out  4   0 WAIT, 1 WRITE, 2 PURGE, 3 BACKGROUND
// fill_done               out  1   one-cycle pulse after last fill write accepted
// BEHAVIOUR
// - Reset: state WAIT, all outputs 0, fill_pending 0, edge-detect register 0, fill counter 0.
// - fill_pending set on fill_background_flag rising edge (registered compare) in any state except
//   BACKGROUND; cleared on BACKGROUND entry. Edges arriving during BACKGROUND are ignored.
// - WAIT: priority fill_pending > pixel. fill_pending: go PURGE if !pixel_fifo_empty, else BACKGROUND.
//   Else if !pixel_fifo_empty: pulse rdreq for 1 cycle, register x/y/colour and target buffer.
//   If x>=H_RES or y>=V_RES the pixel is dropped (popped, no write), stay WAIT; else go WRITE.
// - WRITE: avm_write=1, address/data held stable while waitrequest=1. On accept: write=0, return WAIT.
//   Min 3 cycles per pixel (pop, write, WAIT). rdreq never asserted in WRITE.
// - PURGE: rdreq=1 every cycle while !pixel_fifo_empty (stale pixels overwritten by fill); no writes.
//   Go BACKGROUND the cycle after empty is seen. rdreq never asserted when empty.
// - BACKGROUND: latch colour and target buffer on entry; counter 0..H_RES*V_RES-1, address base+count*4,
//   write held until accepted, counter advances per accept (back-to-back, 1 pixel/cycle with no stall).
//   After last accept: fill_done=1 for 1 cycle, write=0, return WAIT.
// - Target buffer latched per pixel pop / per fill start; current_buffer_flag change mid-write or mid-fill
//   does not affect the in-flight operation.
// - fill_background_flag dropping mid-fill does not abort it.
// - Address arithmetic: y*H_RES+x in 20 bits unsigned, <<2, added modulo 2^32 to base.
// - Reset mid-operation: write dropped immediately, state WAIT, pending fill forgotten.
// TESTING
// 1. Reset, flag=0, FIFO empty -> state 0, write 0, rdreq 0 for 20 cycles.
// 2. cur_buf=0, push {y=2,x=3,0xFF00FF00}, waitrequest=1 for 3 cycles -> one write, address
//    BUF1_BASE+0x140C, data 0xFF00FF00 held 4 cycles, state 1 then 0.
// 3. H_RES=4,V_RES=2, cur_buf=1, colour 0x12345678, flag rises -> 8 writes BUF0_BASE+0x00..0x1C,
//    state 3 throughout, fill_done pulse once, state 0; flag dropped at cycle 3 has no effect.
// 4. 3 pixels queued then flag rises -> state 2, exactly 3 rdreq pulses, no pixel writes, then fill.
// 5. Pixel x=640,y=0 -> popped, no avm_write, state stays 0; next valid pixel written normally.
// 6. Assert reset at fill write 100 -> write 0 same cycle, state 0; no resumed fill after release.

Source files
------------

// File: rtl/rush3d_framebuffer_writer.sv
// Drains rasterised pixels into the back framebuffer over an Avalon-MM write master,
// and performs full-screen background fills on request from the controller.
module rush3d_framebuffer_writer #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter logic [31:0] BUF0_BASE = 32'h0000_0000,
  parameter logic [31:0] BUF1_BASE = 32'h0012_C000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fill_background_flag,
  input  logic [31:0] background_colour,
  input  logic        current_buffer_flag,
  input  logic [51:0] pixel_fifo_data,
  input  logic        pixel_fifo_empty,
  output logic        pixel_fifo_rdreq,
  output logic [31:0] avm_address,
  output logic [31:0] avm_writedata,
  output logic        avm_write,
  input  logic        avm_waitrequest,
  output logic [3:0]  framebuffer_write_state,
  output logic        fill_done
);

  localparam logic [19:0] LAST_PIX = 20'(H_RES * V_RES - 1);

  typedef enum logic [3:0] {
    S_WAIT  = 4'd0,
    S_WRITE = 4'd1,
    S_PURGE = 4'd2,
    S_BG    = 4'd3
  } state_t;

  state_t      state_q;
  logic        flag_q;
  logic        fill_pending_q;
  logic        pop_q;
  logic        pix_ok_q;
  logic        write_q;
  logic        done_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [19:0] count_q;

  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [19:0] pix_lin;
  logic        pix_in_range;
  logic [31:0] draw_base;
  logic        fill_rise;
  logic        fill_req;
  logic        start_fill;
  logic        purge_rd;

  assign pix_y        = pixel_fifo_data[51:42];
  assign pix_x        = pixel_fifo_data[41:32];
  assign pix_lin      = 20'(32'(pix_y) * H_RES + 32'(pix_x));
  assign pix_in_range = (32'(pix_x) < H_RES) && (32'(pix_y) < V_RES);
  // Draw into whichever buffer is not currently being scanned out.
  assign draw_base    = current_buffer_flag ? BUF0_BASE : BUF1_BASE;

  assign fill_rise  = fill_background_flag & ~flag_q;
  assign fill_req   = fill_pending_q | fill_rise;
  assign start_fill = ((state_q == S_WAIT) && !pop_q && fill_req && pixel_fifo_empty) ||
                      ((state_q == S_PURGE) && pixel_fifo_empty);

  // Purge pops must follow the live empty flag, so they bypass the output register.
  assign purge_rd = (state_q == S_PURGE) && !pixel_fifo_empty;

  assign pixel_fifo_rdreq        = pop_q | purge_rd;
  assign avm_address             = addr_q;
  assign avm_writedata           = data_q;
  assign avm_write               = write_q;
  assign framebuffer_write_state = state_q;
  assign fill_done               = done_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_WAIT;
      flag_q         <= 1'b0;
      fill_pending_q <= 1'b0;
      pop_q          <= 1'b0;
      pix_ok_q       <= 1'b0;
      write_q        <= 1'b0;
      done_q         <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      count_q        <= '0;
    end else begin
      flag_q <= fill_background_flag;
      pop_q  <= 1'b0;
      done_q <= 1'b0;

      // A fill start absorbs any edge seen in the same cycle.
      if (start_fill) begin
        fill_pending_q <= 1'b0;
      end else if (fill_rise && (state_q != S_BG)) begin
        fill_pending_q <= 1'b1;
      end

      if (start_fill) begin
        state_q <= S_BG;
        write_q <= 1'b1;
        count_q <= '0;
        addr_q  <= draw_base;
        data_q  <= background_colour;
      end else begin
        case (state_q)
          S_WAIT: begin
            if (pop_q) begin
              if (pix_ok_q) begin
                state_q <= S_WRITE;
                write_q <= 1'b1;
              end
            end else if (fill_req) begin
              state_q <= S_PURGE;
            end else if (!pixel_fifo_empty) begin
              pop_q    <= 1'b1;
              pix_ok_q <= pix_in_range;
              addr_q   <= draw_base + {10'd0, pix_lin, 2'b00};
              data_q   <= pixel_fifo_data[31:0];
            end
          end
          S_WRITE: begin
            if (!avm_waitrequest) begin
              write_q <= 1'b0;
              state_q <= S_WAIT;
            end
          end
          S_PURGE: begin
            state_q <= S_PURGE;
          end
          S_BG: begin
            if (!avm_waitrequest) begin
              if (count_q == LAST_PIX) begin
                write_q <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_WAIT;
              end else begin
                count_q <= count_q + 20'd1;
                addr_q  <= addr_q + 32'd4;
              end
            end
          end
          default: begin
            state_q <= S_WAIT;
            write_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
